// File: rtl/tsn_dgcl_pkg.sv
// Shared definitions for the DGCL read path.
// Contents: FSM state enum, bus widths, beat/page sizes, the packed
// return-beat record stored in the read FIFO, and a helper that computes
// how many beats fit before the next 4 KiB page boundary.
package tsn_dgcl_pkg;

    localparam int BEAT_BYTES = 16;
    localparam int DRAM_AW    = 40;
    localparam int DPRAM_AW   = 16;
    localparam int LEN_W      = 16;
    localparam int PAGE_BYTES = 4096;
    localparam int PAGE_OFS_W = 12;
    localparam int DATA_W     = 128;
    localparam int MEM_LEN_W  = 8;
    localparam int ENTRY_W    = LEN_W + DPRAM_AW + DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_e;

    typedef struct packed {
        logic [LEN_W-1:0]    len;
        logic [DPRAM_AW-1:0] dpram_addr;
        logic [DATA_W-1:0]   data;
    } rd_beat_t;

    // Rounded up so an unaligned address still yields at least one beat.
    function automatic logic [LEN_W-1:0] beats_to_page(input logic [PAGE_OFS_W-1:0] ofs);
        logic [PAGE_OFS_W:0] room;
        room = (PAGE_OFS_W+1)'(PAGE_BYTES) - {1'b0, ofs};
        return LEN_W'((room + (PAGE_OFS_W+1)'(BEAT_BYTES - 1)) >> 4);
    endfunction

endpackage

// File: rtl/dram_rd_engine_if.sv
// Bus bundle for dram_rd_engine.
// rcc_* : read command from the DGCL (addr, dpram addr, length, valid/ready)
// rcd_* : read data returned to the DGCL (data, dpram addr, length, valid/ready)
// mem_req_* : DRAM burst request (byte addr, len = beats-1, valid/ready)
// mem_r* : DRAM read beats (data, valid/ready), in order
// slave  = engine side, master = DGCL/DRAM environment side.
interface dram_rd_engine_if;
    import tsn_dgcl_pkg::*;

    logic [DRAM_AW-1:0]   rcc_dram_addr;
    logic [DPRAM_AW-1:0]  rcc_dpram_addr;
    logic [LEN_W-1:0]     rcc_length;
    logic                 rcc_valid;
    logic                 rcc_ready;

    logic [DPRAM_AW-1:0]  rcd_dpram_addr;
    logic [DATA_W-1:0]    rcd_read_data;
    logic [LEN_W-1:0]     rcd_length;
    logic                 rcd_valid;
    logic                 rcd_ready;

    logic [DRAM_AW-1:0]   mem_req_addr;
    logic [MEM_LEN_W-1:0] mem_req_len;
    logic                 mem_req_valid;
    logic                 mem_req_ready;

    logic [DATA_W-1:0]    mem_rdata;
    logic                 mem_rvalid;
    logic                 mem_rready;

    modport slave (
        input  rcc_dram_addr, rcc_dpram_addr, rcc_length, rcc_valid,
        output rcc_ready,
        output rcd_dpram_addr, rcd_read_data, rcd_length, rcd_valid,
        input  rcd_ready,
        output mem_req_addr, mem_req_len, mem_req_valid,
        input  mem_req_ready,
        input  mem_rdata, mem_rvalid,
        output mem_rready
    );

    modport master (
        output rcc_dram_addr, rcc_dpram_addr, rcc_length, rcc_valid,
        input  rcc_ready,
        input  rcd_dpram_addr, rcd_read_data, rcd_length, rcd_valid,
        output rcd_ready,
        input  mem_req_addr, mem_req_len, mem_req_valid,
        output mem_req_ready,
        output mem_rdata, mem_rvalid,
        input  mem_rready
    );

endinterface

// File: rtl/dram_rd_fifo.sv
// Return-data FIFO for dram_rd_engine.
// Ports: gemmini_clk, reset (async, active-high), push/wdata, pop/rdata,
// full, empty. DEPTH must be a power of two (>= 2). rdata reads 0 when
// empty so the rcd outputs are quiet between transfers.
module dram_rd_fifo
    import tsn_dgcl_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic             gemmini_clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full)  wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop  && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge gemmini_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge gemmini_clk) begin
        if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dram_rd_engine.sv
// DRAM read engine: takes a read command from the DGCL, splits it into
// DRAM bursts of at most MAX_BURST beats, buffers the returned beats in a
// FIFO_DEPTH-entry FIFO and hands them back tagged with their dpram address.
// Ports: gemmini_clk, reset (async assert, active-high), bus (slave modport
// of dram_rd_engine_if carrying the rcc, rcd, mem_req and mem_r channels).
// Build option: define DRAM_RD_4K_SPLIT_EN to also stop every burst at the
// next 4 KiB DRAM page boundary.
//
// state | meaning
// IDLE  | waiting for a command (rcc_ready=1); earlier beats may still drain
// REQ   | presenting the next burst request on mem_req
// DATA  | accepting the burst's beats into the FIFO
module dram_rd_engine
    import tsn_dgcl_pkg::*;
#(
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input logic              gemmini_clk,
    input logic              reset,
    dram_rd_engine_if.slave  bus
);

    state_e              state_q, state_d;
    logic [DRAM_AW-1:0]  addr_q, addr_d;
    logic [DPRAM_AW-1:0] dpram_q, dpram_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [LEN_W-1:0]    beat_idx_q, beat_idx_d;
    logic [LEN_W-1:0]    burst_left_q, burst_left_d;

    logic [LEN_W-1:0]    burst;
    logic                rcc_ready;
    logic                mem_req_valid;
    logic                mem_rready;
    logic                fifo_push;
    logic                fifo_full;
    logic                fifo_empty;
    rd_beat_t            push_beat;
    rd_beat_t            head_beat;
    logic [ENTRY_W-1:0]  fifo_rdata;

    always_comb begin
        burst = remaining_q;
        if (burst > LEN_W'(MAX_BURST)) burst = LEN_W'(MAX_BURST);
`ifdef DRAM_RD_4K_SPLIT_EN
        if (burst > beats_to_page(addr_q[PAGE_OFS_W-1:0]))
            burst = beats_to_page(addr_q[PAGE_OFS_W-1:0]);
`endif
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        dpram_d       = dpram_q;
        len_d         = len_q;
        remaining_d   = remaining_q;
        beat_idx_d    = beat_idx_q;
        burst_left_d  = burst_left_q;
        rcc_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_rready    = 1'b0;
        fifo_push     = 1'b0;
        case (state_q)
            IDLE: begin
                rcc_ready = 1'b1;
                if (bus.rcc_valid) begin
                    addr_d      = bus.rcc_dram_addr;
                    dpram_d     = bus.rcc_dpram_addr;
                    len_d       = bus.rcc_length;
                    remaining_d = bus.rcc_length;
                    beat_idx_d  = '0;
                    if (bus.rcc_length != '0) state_d = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    burst_left_d = burst;
                    state_d      = DATA;
                end
            end
            DATA: begin
                // Full FIFO blocks the beat even if rcd pops this cycle.
                mem_rready = !fifo_full;
                if (bus.mem_rvalid && !fifo_full) begin
                    fifo_push    = 1'b1;
                    addr_d       = addr_q + DRAM_AW'(BEAT_BYTES);
                    remaining_d  = remaining_q - LEN_W'(1);
                    beat_idx_d   = beat_idx_q + LEN_W'(1);
                    burst_left_d = burst_left_q - LEN_W'(1);
                    if (burst_left_q == LEN_W'(1))
                        state_d = (remaining_q != LEN_W'(1)) ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gemmini_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            dpram_q      <= '0;
            len_q        <= '0;
            remaining_q  <= '0;
            beat_idx_q   <= '0;
            burst_left_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            dpram_q      <= dpram_d;
            len_q        <= len_d;
            remaining_q  <= remaining_d;
            beat_idx_q   <= beat_idx_d;
            burst_left_q <= burst_left_d;
        end
    end

    assign push_beat = '{len: len_q, dpram_addr: dpram_q + beat_idx_q, data: bus.mem_rdata};

    dram_rd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .gemmini_clk (gemmini_clk),
        .reset       (reset),
        .push        (fifo_push),
        .wdata       (push_beat),
        .pop         (bus.rcd_ready),
        .rdata       (fifo_rdata),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    assign head_beat = rd_beat_t'(fifo_rdata);

    // State is IDLE while reset is held, so gate ready to keep it low then.
    assign bus.rcc_ready      = rcc_ready & ~reset;
    assign bus.mem_req_valid  = mem_req_valid;
    assign bus.mem_req_addr   = mem_req_valid ? addr_q : '0;
    assign bus.mem_req_len    = mem_req_valid ? MEM_LEN_W'(burst - LEN_W'(1)) : '0;
    assign bus.mem_rready     = mem_rready;
    assign bus.rcd_valid      = ~fifo_empty;
    assign bus.rcd_read_data  = head_beat.data;
    assign bus.rcd_dpram_addr = head_beat.dpram_addr;
    assign bus.rcd_length     = head_beat.len;

endmodule

// File: tb/tb_dram_rd_engine.sv
module tb_dram_rd_engine;

    localparam int MAX_BURST  = 16;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic [39:0] addr;
        logic [15:0] dp;
        logic [15:0] len;
    } cmd_t;

    typedef struct {
        logic [39:0] addr;
        logic [7:0]  len;
    } req_t;

    typedef struct {
        logic [15:0]  dp;
        logic [15:0]  len;
        logic [127:0] data;
    } beat_t;

    logic gemmini_clk = 1'b0;
    logic reset       = 1'b0;

    dram_rd_engine_if bus_if();

    dram_rd_engine #(
        .MAX_BURST  (MAX_BURST),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .gemmini_clk (gemmini_clk),
        .reset       (reset),
        .bus         (bus_if)
    );

    always #5 gemmini_clk = ~gemmini_clk;

    int checks = 0;
    int errors = 0;

    cmd_t        cmd_q[$];
    req_t        exp_req_q[$];
    beat_t       exp_beat_q[$];
    logic [39:0] pend_q[$];

    bit full_speed  = 1'b1;
    bit hold_rcd    = 1'b0;
    bit junk_en     = 1'b1;
    bit rcc_fired   = 1'b0;
    bit exp_rdy_chk = 1'b0;
    bit exp_rdy     = 1'b0;
    bit lat_chk     = 1'b0;
    int beats_acc   = 0;
    int nreq        = 0;

    task automatic chk_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] data_of(input logic [39:0] a);
        return {a, ~a, a[23:0] ^ 24'hC3C3C3, 24'h5A5A5A};
    endfunction

    // Reference: split the command by the burst rules, list every beat.
    function automatic void model_cmd(input cmd_t c);
        longint unsigned cur = 64'(c.addr);
        int rem = int'(c.len);
        int b;
`ifdef DRAM_RD_4K_SPLIT_EN
        int pg;
`endif
        req_t r;
        beat_t bt;
        while (rem > 0) begin
            b = (rem < MAX_BURST) ? rem : MAX_BURST;
`ifdef DRAM_RD_4K_SPLIT_EN
            pg = (4096 - int'(cur % 4096) + 15) / 16;
            if (b > pg) b = pg;
`endif
            r.addr = cur[39:0];
            r.len  = 8'(b - 1);
            exp_req_q.push_back(r);
            cur = (cur + 64'(16 * b)) % (64'd1 << 40);
            rem -= b;
        end
        for (int i = 0; i < int'(c.len); i++) begin
            bt.dp   = 16'(int'(c.dp) + i);
            bt.len  = c.len;
            bt.data = data_of(c.addr + 40'(16 * i));
            exp_beat_q.push_back(bt);
        end
    endfunction

    task automatic cycle();
        cmd_t c;
        req_t r;
        beat_t bt;
        @(negedge gemmini_clk);
        if (rcc_fired) begin
            bus_if.rcc_valid = 1'b0;
            rcc_fired = 1'b0;
        end
        if (!bus_if.rcc_valid && cmd_q.size() != 0 && (full_speed || $urandom_range(0, 2) != 0)) begin
            bus_if.rcc_dram_addr  = cmd_q[0].addr;
            bus_if.rcc_dpram_addr = cmd_q[0].dp;
            bus_if.rcc_length     = cmd_q[0].len;
            bus_if.rcc_valid      = 1'b1;
        end
        bus_if.mem_req_ready = full_speed ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (pend_q.size() != 0) begin
            bus_if.mem_rvalid = full_speed ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus_if.mem_rdata  = data_of(pend_q[0]);
        end else begin
            bus_if.mem_rvalid = junk_en && ($urandom_range(0, 1) != 0);
            bus_if.mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
        end
        bus_if.rcd_ready = hold_rcd ? 1'b0 : (full_speed ? 1'b1 : ($urandom_range(0, 1) != 0));
        #1;
        if (exp_rdy_chk) begin
            chk_eq("rcc_ready_after_cmd", bus_if.rcc_ready, exp_rdy);
            exp_rdy_chk = 1'b0;
        end
        if (lat_chk) begin
            chk_eq("rcd_valid_latency", bus_if.rcd_valid, 1'b1);
            lat_chk = 1'b0;
        end
        if (bus_if.rcc_valid && bus_if.rcc_ready) begin
            c = cmd_q.pop_front();
            model_cmd(c);
            rcc_fired   = 1'b1;
            exp_rdy_chk = 1'b1;
            exp_rdy     = (c.len == 16'd0);
        end
        if (bus_if.mem_req_valid && bus_if.mem_req_ready) begin
            nreq++;
            if (exp_req_q.size() == 0) begin
                chk_eq("req_unexpected", 1'b1, 1'b0);
            end else begin
                r = exp_req_q.pop_front();
                chk_eq("req_addr", bus_if.mem_req_addr, r.addr);
                chk_eq("req_len", bus_if.mem_req_len, r.len);
            end
            for (int k = 0; k <= int'(bus_if.mem_req_len); k++)
                pend_q.push_back(bus_if.mem_req_addr + 40'(16 * k));
        end
        if (bus_if.mem_rvalid) begin
            if (pend_q.size() == 0) begin
                chk_eq("rready_outside_data", bus_if.mem_rready, 1'b0);
            end else if (bus_if.mem_rready) begin
                void'(pend_q.pop_front());
                beats_acc++;
                lat_chk = 1'b1;
            end
        end
        if (bus_if.rcd_valid && bus_if.rcd_ready) begin
            if (exp_beat_q.size() == 0) begin
                chk_eq("rcd_unexpected", 1'b1, 1'b0);
            end else begin
                bt = exp_beat_q.pop_front();
                chk_eq("rcd_data", bus_if.rcd_read_data, bt.data);
                chk_eq("rcd_dpram_addr", bus_if.rcd_dpram_addr, bt.dp);
                chk_eq("rcd_length", bus_if.rcd_length, bt.len);
            end
        end
    endtask

    function automatic bit busy();
        return cmd_q.size() != 0 || exp_req_q.size() != 0 || exp_beat_q.size() != 0 ||
               pend_q.size() != 0 || bus_if.rcc_valid;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            cycle();
            n++;
        end
        chk_eq({tag, "_completed"}, busy(), 1'b0);
        cycle();
        cycle();
        chk_eq({tag, "_rcd_quiet"}, bus_if.rcd_valid, 1'b0);
    endtask

    task automatic send(input logic [39:0] a, input logic [15:0] dp, input logic [15:0] len);
        cmd_t c;
        c.addr = a;
        c.dp   = dp;
        c.len  = len;
        cmd_q.push_back(c);
    endtask

    task automatic clear_model();
        cmd_q.delete();
        exp_req_q.delete();
        exp_beat_q.delete();
        pend_q.delete();
        rcc_fired   = 1'b0;
        exp_rdy_chk = 1'b0;
        lat_chk     = 1'b0;
        bus_if.rcc_valid  = 1'b0;
        bus_if.mem_rvalid = 1'b0;
    endtask

    initial begin
        logic [63:0] r64;
        logic [39:0] a;
        int n;
        int mode;

        bus_if.rcc_dram_addr  = '0;
        bus_if.rcc_dpram_addr = '0;
        bus_if.rcc_length     = '0;
        bus_if.rcc_valid      = 1'b0;
        bus_if.rcd_ready      = 1'b0;
        bus_if.mem_req_ready  = 1'b0;
        bus_if.mem_rdata      = '0;
        bus_if.mem_rvalid     = 1'b0;

        #1 reset = 1'b1;
        #2;
        chk_eq("rst_rcc_ready", bus_if.rcc_ready, 1'b0);
        chk_eq("rst_rcd_valid", bus_if.rcd_valid, 1'b0);
        chk_eq("rst_mem_req_valid", bus_if.mem_req_valid, 1'b0);
        chk_eq("rst_mem_rready", bus_if.mem_rready, 1'b0);
        chk_eq("rst_mem_req_addr", bus_if.mem_req_addr, 40'd0);
        chk_eq("rst_rcd_data", bus_if.rcd_read_data, 128'd0);
        repeat (2) @(posedge gemmini_clk);
        @(negedge gemmini_clk);
        reset = 1'b0;
        cycle();
        chk_eq("release_rcc_ready", bus_if.rcc_ready, 1'b1);

        // Basic 4-beat command
        full_speed = 1'b1;
        nreq = 0;
        send(40'h1000, 16'h0020, 16'd4);
        drain("len4", 200);
        chk_eq("len4_nreq", nreq, 1);

        // 40 beats -> three bursts
        nreq = 0;
        send(40'h0, 16'h0, 16'd40);
        drain("len40", 400);
        chk_eq("len40_nreq", nreq, 3);

        // Page-crossing command
        nreq = 0;
        send(40'hFC0, 16'h0100, 16'd8);
        drain("page", 200);
`ifdef DRAM_RD_4K_SPLIT_EN
        chk_eq("page_nreq", nreq, 2);
`else
        chk_eq("page_nreq", nreq, 1);
`endif

        // Zero length dropped, then dpram wrap, then 40-bit address wrap
        nreq = 0;
        send(40'h5000, 16'h0010, 16'd0);
        drain("zero", 100);
        chk_eq("zero_nreq", nreq, 0);
        chk_eq("zero_rcc_ready", bus_if.rcc_ready, 1'b1);
        send(40'h6000, 16'hFFFE, 16'd3);
        drain("dpwrap", 200);
        send(40'hFF_FFFF_FFE0, 16'h0200, 16'd5);
        drain("addrwrap", 200);

        // Consumer stalled: FIFO fills and mem_rready stays low
        hold_rcd  = 1'b1;
        beats_acc = 0;
        send(40'h2000, 16'h0000, 16'd8);
        repeat (30) cycle();
        chk_eq("hold_beats_acc", beats_acc, FIFO_DEPTH);
        chk_eq("hold_mem_rready", bus_if.mem_rready, 1'b0);
        chk_eq("hold_rcd_valid", bus_if.rcd_valid, 1'b1);
        hold_rcd = 1'b0;
        drain("hold", 300);

        // Reset in the middle of a command
        beats_acc = 0;
        n = 0;
        send(40'h3000, 16'h0040, 16'd4);
        while (beats_acc < 2 && n < 40) begin
            cycle();
            n++;
        end
        chk_eq("midrst_two_beats", beats_acc, 2);
        @(posedge gemmini_clk);
        #1 reset = 1'b1;
        clear_model();
        #1;
        chk_eq("midrst_rcd_valid", bus_if.rcd_valid, 1'b0);
        chk_eq("midrst_rcc_ready", bus_if.rcc_ready, 1'b0);
        chk_eq("midrst_mem_req_valid", bus_if.mem_req_valid, 1'b0);
        chk_eq("midrst_mem_rready", bus_if.mem_rready, 1'b0);
        @(posedge gemmini_clk);
        @(negedge gemmini_clk);
        reset = 1'b0;
        cycle();
        chk_eq("midrst_idle_after", bus_if.rcc_ready, 1'b1);
        chk_eq("midrst_no_partial", bus_if.rcd_valid, 1'b0);
        send(40'h4000, 16'h0080, 16'd6);
        drain("after_rst", 200);

        // Randomized traffic, back-to-back commands, random readies
        full_speed = 1'b0;
        for (int it = 0; it < 30; it++) begin
            for (int j = 0; j < 1 + int'($urandom_range(0, 2)); j++) begin
                r64  = {$urandom, $urandom};
                mode = int'($urandom_range(0, 3));
                case (mode)
                    0:       a = {r64[39:12], 8'hF0 + 8'(r64[3:0]), 4'h0};
                    1:       a = {32'hFFFF_FFFF, r64[7:4], 4'h0};
                    default: a = {r64[39:4], 4'h0};
                endcase
                send(a, r64[63:48],
                     ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 2))
                                                 : 16'($urandom_range(1, 48)));
            end
            drain("rand", 4000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
